// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: sequences each instruction over 3-5 cycles,
// stalls on the memory handshake, traps illegal opcodes and pulses InstrDone.
module multicycle_control #(
  parameter int                  OPCODE_W = 6,
  parameter int                  ALUOP_W  = 3,
  parameter logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(10),
  parameter logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(15),
  parameter logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43),
  parameter logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4),
  parameter logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2),
  parameter logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7),
  parameter bit                  TRAP_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic [1:0]          MemToReg,
  output logic [1:0]          RegDest,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                RegWrite,
  output logic                Illegal,
  output logic                InstrDone,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  JAL    = 4'd10, TRAP   = 4'd11
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b110);

  state_t stateR;
  state_t nextState;
  logic   isStoreR;
  logic   illegalR;

  assign State   = stateR;
  assign Illegal = illegalR;

  // Output decode and next state; everything is forced low while rst_n is low
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 2'b00;
    RegDest     = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_FUNCT;
    PCSource    = 2'b00;
    RegWrite    = 1'b0;
    InstrDone   = 1'b0;
    nextState   = FETCH;
    if (rst_n) begin
      case (stateR)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = ALU_ADD;
          if (MemReady) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            nextState = DECODE;
          end else begin
            nextState = FETCH;
          end
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          ALUOp   = ALU_ADD;
          if (OpCode == OP_LW || OpCode == OP_SW) begin
            nextState = MEMADR;
          end else if (OpCode == OP_RTYPE) begin
            nextState = EXEC;
          end else if (OpCode == OP_BEQ) begin
            nextState = BRANCH;
          end else if (OpCode == OP_J) begin
            nextState = JUMP;
          end else if (OpCode == OP_JAL) begin
            nextState = JAL;
          end else if (TRAP_EN) begin
            nextState = TRAP;
          end else begin
            nextState = FETCH;
            InstrDone = 1'b1;
          end
        end
        MEMADR: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ALUOp     = ALU_ADD;
          nextState = isStoreR ? MEMWR : MEMRD;
        end
        MEMRD: begin
          MemRead   = 1'b1;
          IorD      = 1'b1;
          nextState = MemReady ? MEMWB : MEMRD;
        end
        MEMWB: begin
          RegWrite  = 1'b1;
          MemToReg  = 2'b01;
          InstrDone = 1'b1;
          nextState = FETCH;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (MemReady) begin
            InstrDone = 1'b1;
            nextState = FETCH;
          end else begin
            nextState = MEMWR;
          end
        end
        EXEC: begin
          ALUSrcA   = 1'b1;
          ALUOp     = ALU_FUNCT;
          nextState = ALUWB;
        end
        ALUWB: begin
          RegWrite  = 1'b1;
          RegDest   = 2'b01;
          InstrDone = 1'b1;
          nextState = FETCH;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          InstrDone   = 1'b1;
          nextState   = FETCH;
        end
        JUMP: begin
          PCWrite   = 1'b1;
          PCSource  = 2'b10;
          InstrDone = 1'b1;
          nextState = FETCH;
        end
        JAL: begin
          PCWrite   = 1'b1;
          PCSource  = 2'b10;
          RegWrite  = 1'b1;
          RegDest   = 2'b10;
          MemToReg  = 2'b10;
          InstrDone = 1'b1;
          nextState = FETCH;
        end
        TRAP: begin
          nextState = TRAP;
        end
        default: begin
          nextState = FETCH;
        end
      endcase
    end else begin
      nextState = FETCH;
    end
  end

  // State register; the load/store choice is captured in DECODE since OpCode is only valid there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR   <= FETCH;
      isStoreR <= 1'b0;
      illegalR <= 1'b0;
    end else begin
      stateR   <= nextState;
      illegalR <= illegalR | ((stateR == DECODE) && (nextState == TRAP));
      if (stateR == DECODE) begin
        isStoreR <= (OpCode == OP_SW);
      end else begin
        isStoreR <= isStoreR;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected cycle
// sequences are built from the instruction class and random memory wait counts.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] OpCode = 6'd0;
  logic       MemReady = 1'b1;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mr, mw, irw;
    logic [1:0] m2r, rd;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic       rw, ill, done;
  } outs_t;

  typedef struct {
    logic       rdy;
    logic [5:0] op;
    outs_t      e1;
    outs_t      e0;
    logic       chk0;
    string      tag;
  } rec_t;

  rec_t  q[$];
  int    nChecks = 0;
  int    nFails  = 0;
  outs_t got1, got0;

  // dut1 traps illegal opcodes, dut0 treats them as NOPs
  logic       pcw1, pcwc1, iord1, mr1, mw1, irw1, sa1, rw1, ill1, done1;
  logic [1:0] m2r1, rd1, sb1, pcs1;
  logic [2:0] aop1;
  logic [3:0] st1;
  logic       pcw0, pcwc0, iord0, mr0, mw0, irw0, sa0, rw0, ill0, done0;
  logic [1:0] m2r0, rd0, sb0, pcs0;
  logic [2:0] aop0;
  logic [3:0] st0;

  multicycle_control #(.TRAP_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mr1),
    .MemWrite(mw1), .IRWrite(irw1), .MemToReg(m2r1), .RegDest(rd1),
    .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1), .PCSource(pcs1),
    .RegWrite(rw1), .Illegal(ill1), .InstrDone(done1), .State(st1));

  multicycle_control #(.TRAP_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mr0),
    .MemWrite(mw0), .IRWrite(irw0), .MemToReg(m2r0), .RegDest(rd0),
    .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0), .PCSource(pcs0),
    .RegWrite(rw0), .Illegal(ill0), .InstrDone(done0), .State(st0));

  assign got1 = {st1, pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, sa1, sb1, aop1, pcs1, rw1, ill1, done1};
  assign got0 = {st0, pcw0, pcwc0, iord0, mr0, mw0, irw0, m2r0, rd0, sa0, sb0, aop0, pcs0, rw0, ill0, done0};

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] rndOp();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rndBit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic [5:0] op, input outs_t e, input string tag);
    rec_t r;
    r.rdy = rdy; r.op = op; r.e1 = e; r.e0 = e; r.chk0 = 1'b1; r.tag = tag;
    q.push_back(r);
  endtask

  function automatic outs_t fetchOut(input logic rdy);
    outs_t e = '0;
    e.st = 4'd0; e.mr = 1'b1; e.sb = 2'b01; e.aop = 3'b010;
    e.irw = rdy; e.pcw = rdy;
    return e;
  endfunction

  function automatic outs_t decodeOut();
    outs_t e = '0;
    e.st = 4'd1; e.sb = 2'b11; e.aop = 3'b010;
    return e;
  endfunction

  task automatic addFetch(input int wf);
    for (int i = 0; i < wf; i++) push(1'b0, rndOp(), fetchOut(1'b0), "fetch_wait");
    push(1'b1, rndOp(), fetchOut(1'b1), "fetch");
  endtask

  // Expected cycle sequence for one legal instruction with wf/wm memory wait cycles
  task automatic addInstr(input logic [5:0] op, input int wf, input int wm);
    outs_t e;
    addFetch(wf);
    push(rndBit(), op, decodeOut(), "decode");
    case (op)
      6'd15, 6'd43: begin
        e = '0; e.st = 4'd2; e.sa = 1'b1; e.sb = 2'b10; e.aop = 3'b010;
        push(rndBit(), rndOp(), e, "memadr");
        e = '0; e.iord = 1'b1;
        if (op == 6'd15) begin
          e.st = 4'd3; e.mr = 1'b1;
          for (int i = 0; i <= wm; i++) push(i == wm, rndOp(), e, "memrd");
          e = '0; e.st = 4'd4; e.rw = 1'b1; e.m2r = 2'b01; e.done = 1'b1;
          push(rndBit(), rndOp(), e, "memwb");
        end else begin
          e.st = 4'd5; e.mw = 1'b1;
          for (int i = 0; i < wm; i++) push(1'b0, rndOp(), e, "memwr_wait");
          e.done = 1'b1;
          push(1'b1, rndOp(), e, "memwr");
        end
      end
      6'd10: begin
        e = '0; e.st = 4'd6; e.sa = 1'b1;
        push(rndBit(), rndOp(), e, "exec");
        e = '0; e.st = 4'd7; e.rw = 1'b1; e.rd = 2'b01; e.done = 1'b1;
        push(rndBit(), rndOp(), e, "aluwb");
      end
      6'd4: begin
        e = '0; e.st = 4'd8; e.sa = 1'b1; e.aop = 3'b110; e.pcwc = 1'b1; e.pcs = 2'b01; e.done = 1'b1;
        push(rndBit(), rndOp(), e, "branch");
      end
      6'd2: begin
        e = '0; e.st = 4'd9; e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1;
        push(rndBit(), rndOp(), e, "jump");
      end
      6'd7: begin
        e = '0; e.st = 4'd10; e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1;
        e.rd = 2'b10; e.m2r = 2'b10; e.done = 1'b1;
        push(rndBit(), rndOp(), e, "jal");
      end
      default: begin
        $display("FAIL addInstr: got opcode %0d required a legal opcode", op);
        nFails++;
      end
    endcase
  endtask

  // Drive one record per cycle just after the edge, compare at the falling edge
  task automatic runQueue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      MemReady = r.rdy;
      OpCode   = r.op;
      @(negedge clk);
      check(r.tag, got1, r.e1);
      if (r.chk0) check({r.tag, "_nop"}, got0, r.e0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish required finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] legal [6];
    outs_t      e;
    rec_t       r;
    legal = '{6'd10, 6'd15, 6'd43, 6'd4, 6'd2, 6'd7};

    // Reset: all outputs low before any clock and while rst_n stays low
    #2;
    check("reset_async", got1, '0);
    check("reset_async_nop", got0, '0);
    @(posedge clk);
    @(negedge clk);
    check("reset_held", got1, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed: R-type, LW with 2 waits, SW with 3 fetch waits, BEQ then JAL
    addInstr(6'd10, 0, 0);
    addInstr(6'd15, 0, 2);
    addInstr(6'd43, 3, 0);
    addInstr(6'd4, 0, 0);
    addInstr(6'd7, 0, 0);
    addInstr(6'd2, 1, 0);
    runQueue();

    // Random legal instruction stream with random memory latency
    for (int n = 0; n < 40; n++) begin
      addInstr(legal[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
    end
    runQueue();

    // Asynchronous reset in the middle of a stalled store
    addInstr(6'd43, 0, 5);
    for (int i = 0; i < 4; i++) void'(q.pop_back());
    runQueue();
    MemReady = 1'b0;
    #2;
    e = '0; e.st = 4'd5; e.mw = 1'b1; e.iord = 1'b1;
    check("memwr_before_reset", got1, e);
    rst_n = 1'b0;
    #1;
    check("memwr_async_reset", got1, '0);
    check("memwr_async_reset_nop", got0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Illegal opcode 63: dut1 traps for good, dut0 finishes as a NOP
    addFetch(0);
    r.rdy = 1'b1; r.op = 6'd63; r.e1 = decodeOut(); r.e0 = decodeOut(); r.e0.done = 1'b1;
    r.chk0 = 1'b1; r.tag = "decode_illegal";
    q.push_back(r);
    e = '0; e.st = 4'd11; e.ill = 1'b1;
    r.rdy = 1'b0; r.op = rndOp(); r.e1 = e; r.e0 = fetchOut(1'b0); r.tag = "trap_enter";
    q.push_back(r);
    for (int i = 0; i < 20; i++) begin
      r.rdy = rndBit(); r.op = rndOp(); r.e1 = e; r.chk0 = 1'b0; r.tag = "trap_hold";
      q.push_back(r);
    end
    runQueue();
    rst_n = 1'b0;
    #2;
    check("trap_reset_clear", got1, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    addInstr(6'd10, 1, 0);
    addInstr(6'd15, 0, 0);
    runQueue();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
